// File: rtl/posit_add_sequencer.sv
// Posit adder front end: accepts an operand pair, decodes both through one shared
// field extractor on consecutive cycles, then presents a magnitude-ordered bundle.

module posit_data_extraction #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic [N-1:0]    x,
  output logic            sign,
  output logic [RS+ES:0]  scale,
  output logic [N-ES+2:0] mant,
  output logic            inf,
  output logic            zero
);
  logic [N-1:0]    mag;
  logic [N-2:0]    body;
  logic [N-2:0]    shifted;
  logic [RS-1:0]   run;
  logic [RS:0]     shamt;
  logic [RS:0]     regime;
  logic            r0;
  logic            done;

  always_comb begin
    sign  = x[N-1];
    zero  = (x == '0);
    inf   = (x == {1'b1, {(N-1){1'b0}}});
    mag   = x[N-1] ? ((~x) + {{(N-1){1'b0}}, 1'b1}) : x;
    body  = mag[N-2:0];
    r0    = body[N-2];
    run   = RS'(1);
    done  = 1'b0;
    // Regime is the run of bits equal to the first bit after the sign.
    for (int i = N - 3; i >= 0; i--) begin
      if (!done && (body[i] == r0)) begin
        run = run + RS'(1);
      end else begin
        done = 1'b1;
      end
    end
    shamt   = {1'b0, run} + (RS+1)'(1);
    shifted = body << shamt;
    regime  = r0 ? ({1'b0, run} - (RS+1)'(1)) : (-{1'b0, run});
    scale   = {regime, shifted[N-2 -: ES]};
    mant    = {~zero, shifted[N-2-ES:0], 3'b000};
  end
endmodule

module posit_add_sequencer #(
  parameter int N  = 8,
  parameter int ES = 3,
  parameter int RS = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             big_sign,
  output logic             small_sign,
  output logic [RS+ES:0]   big_scale,
  output logic [RS+ES:0]   small_scale,
  output logic [N-ES+2:0]  big_mant,
  output logic [N-ES+2:0]  small_mant,
  output logic [RS+ES+1:0] scale_diff,
  output logic             swapped,
  output logic             out_nar,
  output logic             out_zero_a,
  output logic             out_zero_b,
  output logic [2:0]       state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  typedef enum logic [2:0] {IDLE, EXT_A, EXT_B, CMP, HOLD} state_t;
  state_t state;

  logic [N-1:0]    a_q, b_q, ext_in;
  logic            x_sign, x_inf, x_zero;
  logic [RS+ES:0]  x_scale;
  logic [N-ES+2:0] x_mant;

  logic            a_sign, b_sign, a_inf, b_inf, a_zero, b_zero;
  logic [RS+ES:0]  a_scale, b_scale;
  logic [N-ES+2:0] a_mant, b_mant;

  logic             a_ge_b, swap_c;
  logic [RS+ES:0]   big_scale_c, small_scale_c;
  logic [RS+ES+1:0] diff_c;

  assign ext_in    = (state == EXT_B) ? b_q : a_q;
  assign in_ready  = rst_n & (state == IDLE);
  assign state_dbg = state;

  posit_data_extraction #(.N(N), .ES(ES), .RS(RS)) u_ext (
    .x     (ext_in),
    .sign  (x_sign),
    .scale (x_scale),
    .mant  (x_mant),
    .inf   (x_inf),
    .zero  (x_zero)
  );

  // Zero is always the small operand; ties keep a as big.
  always_comb begin
    a_ge_b = ($signed(a_scale) > $signed(b_scale)) ||
             ((a_scale == b_scale) && (a_mant >= b_mant));
    if (a_zero)      swap_c = ~b_zero;
    else if (b_zero) swap_c = 1'b0;
    else             swap_c = ~a_ge_b;
    big_scale_c   = swap_c ? b_scale : a_scale;
    small_scale_c = swap_c ? a_scale : b_scale;
    diff_c = (a_zero && b_zero) ? '0 :
             ({big_scale_c[RS+ES], big_scale_c} - {small_scale_c[RS+ES], small_scale_c});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      a_inf       <= 1'b0;
      b_inf       <= 1'b0;
      a_zero      <= 1'b0;
      b_zero      <= 1'b0;
      a_scale     <= '0;
      b_scale     <= '0;
      a_mant      <= '0;
      b_mant      <= '0;
      out_valid   <= 1'b0;
      big_sign    <= 1'b0;
      small_sign  <= 1'b0;
      big_scale   <= '0;
      small_scale <= '0;
      big_mant    <= '0;
      small_mant  <= '0;
      scale_diff  <= '0;
      swapped     <= 1'b0;
      out_nar     <= 1'b0;
      out_zero_a  <= 1'b0;
      out_zero_b  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            state <= EXT_A;
          end
        end
        EXT_A: begin
          a_sign  <= x_sign;
          a_scale <= x_scale;
          a_mant  <= x_mant;
          a_inf   <= x_inf;
          a_zero  <= x_zero;
          state   <= EXT_B;
        end
        EXT_B: begin
          b_sign  <= x_sign;
          b_scale <= x_scale;
          b_mant  <= x_mant;
          b_inf   <= x_inf;
          b_zero  <= x_zero;
          state   <= CMP;
        end
        CMP: begin
          big_sign    <= swap_c ? b_sign : a_sign;
          small_sign  <= swap_c ? a_sign : b_sign;
          big_scale   <= big_scale_c;
          small_scale <= small_scale_c;
          big_mant    <= swap_c ? b_mant : a_mant;
          small_mant  <= swap_c ? a_mant : b_mant;
          scale_diff  <= diff_c;
          swapped     <= swap_c;
          out_nar     <= a_inf | b_inf;
          out_zero_a  <= a_zero;
          out_zero_b  <= b_zero;
          out_valid   <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_posit_add_sequencer.sv
// Randomized and directed bench for posit_add_sequencer against a value-level posit model.

module tb_posit_add_sequencer;
  localparam int N  = 8;
  localparam int ES = 3;
  localparam int RS = 3;
  localparam int W  = 44;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     a = '0;
  logic [N-1:0]     b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             big_sign, small_sign;
  logic [RS+ES:0]   big_scale, small_scale;
  logic [N-ES+2:0]  big_mant, small_mant;
  logic [RS+ES+1:0] scale_diff;
  logic             swapped, out_nar, out_zero_a, out_zero_b;
  logic [2:0]       state_dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  posit_add_sequencer #(.N(N), .ES(ES), .RS(RS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .big_sign    (big_sign),
    .small_sign  (small_sign),
    .big_scale   (big_scale),
    .small_scale (small_scale),
    .big_mant    (big_mant),
    .small_mant  (small_mant),
    .scale_diff  (scale_diff),
    .swapped     (swapped),
    .out_nar     (out_nar),
    .out_zero_a  (out_zero_a),
    .out_zero_b  (out_zero_b),
    .state_dbg   (state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] observed();
    return {big_sign, small_sign, big_scale, small_scale, big_mant, small_mant,
            scale_diff, swapped, out_nar, out_zero_a, out_zero_b};
  endfunction

  // Posit value decode from the bit-pattern definition.
  function automatic void decode(input logic [7:0] p, output int mag, output int scale,
                                 output int mant);
    int r0, k, regime, rem, ex, fb, frac;
    mag = p[7] ? ((256 - int'(p)) % 256) : int'(p);
    r0  = (mag >> 6) & 1;
    k   = 1;
    for (int i = 5; i >= 0; i--) begin
      if (((mag >> i) & 1) == r0) k++;
      else break;
    end
    regime = (r0 == 1) ? (k - 1) : -k;
    rem = 6 - k;
    if (rem < 0) rem = 0;
    if (rem >= ES) ex = (mag >> (rem - ES)) & 7;
    else ex = (mag & ((1 << rem) - 1)) << (ES - rem);
    fb = (rem > ES) ? (rem - ES) : 0;
    frac = mag & ((1 << fb) - 1);
    mant = ((mag == 0) ? 0 : 128) | (frac << (7 - fb));
    scale = regime * 8 + ex;
  endfunction

  // Posit magnitude order equals unsigned order of the absolute bit patterns.
  function automatic logic [W-1:0] model(input logic [7:0] pa, input logic [7:0] pb);
    int ma, mb, sa, sb, na, nb, diff;
    logic sw, nar, za, zb;
    logic [6:0] bs, ss;
    logic [7:0] bm, sm, d;
    decode(pa, ma, sa, na);
    decode(pb, mb, sb, nb);
    za  = (pa == 8'h00);
    zb  = (pb == 8'h00);
    nar = (pa == 8'h80) || (pb == 8'h80);
    sw  = (mb > ma);
    bs  = sw ? sb[6:0] : sa[6:0];
    ss  = sw ? sa[6:0] : sb[6:0];
    bm  = sw ? nb[7:0] : na[7:0];
    sm  = sw ? na[7:0] : nb[7:0];
    diff = (za && zb) ? 0 : (sw ? (sb - sa) : (sa - sb));
    d   = diff[7:0];
    return {sw ? pb[7] : pa[7], sw ? pa[7] : pb[7], bs, ss, bm, sm, d, sw, nar, za, zb};
  endfunction

  task automatic compare_bundle(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] obs;
    obs = observed();
    if (exp[2]) check_eq({tag, "_flags"}, 64'(obs[2:0]), 64'(exp[2:0]));
    else        check_eq({tag, "_bundle"}, 64'(obs), 64'(exp));
  endtask

  // driver: offer one pair, then hold the result for stall cycles
  task automatic run_pair(input logic [7:0] pa, input logic [7:0] pb, input int stall);
    int lat;
    logic [W-1:0] exp, held;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    out_ready = (stall == 0);
    a = pa;
    b = pb;
    in_valid = 1'b1;
    exp_q.push_back(model(pa, pb));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    check_eq("in_ready_busy", 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 64'(lat), 64'd3);
    exp = exp_q.pop_front();
    compare_bundle("result", exp);
    held = observed();
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_in_ready", 64'(in_ready), 64'd0);
      check_eq("hold_stable", 64'(observed()), 64'(held));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("valid_drop", 64'(out_valid), 64'd0);
    check_eq("in_ready_after", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [7:0] ra, rb;
    #1;
    check_eq("reset_outputs", 64'({in_ready, out_valid, observed()}), 64'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("reset_in_ready", 64'(in_ready), 64'd1);

    run_pair(8'h40, 8'h50, 0);
    check_eq("d1_swapped", 64'(swapped), 64'd1);
    check_eq("d1_big_scale", 64'(big_scale), 64'd4);
    check_eq("d1_scale_diff", 64'(scale_diff), 64'd4);
    run_pair(8'h40, 8'h20, 0);
    check_eq("d2_small_scale", 64'(small_scale), 64'h78);
    check_eq("d2_scale_diff", 64'(scale_diff), 64'd8);
    run_pair(8'h00, 8'hC0, 0);
    check_eq("d3_flags", 64'({out_zero_a, swapped, big_sign}), 64'b111);
    run_pair(8'h80, 8'h40, 0);
    check_eq("d4_nar", 64'(out_nar), 64'd1);
    run_pair(8'h40, 8'h40, 5);
    check_eq("d5_swapped", 64'(swapped), 64'd0);
    run_pair(8'h00, 8'h00, 1);
    check_eq("d6_scale_diff", 64'(scale_diff), 64'd0);
    run_pair(8'h01, 8'h7F, 0);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: ra = 8'h00;
        1: rb = 8'h00;
        2: rb = ra;
        3: rb = 8'(-ra);
        4: ra = 8'h80;
        default: ;
      endcase
      run_pair(ra, rb, $urandom_range(0, 2));
    end

    // reset while the second operand is being extracted
    run_pair(8'h5A, 8'h33, 0);
    a = 8'h6C;
    b = 8'h21;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("midreset_state_ext_b", 64'(state_dbg), 64'd2);
    rst_n = 1'b0;
    #1;
    check_eq("midreset_outputs", 64'({in_ready, out_valid, observed()}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midreset_in_ready", 64'(in_ready), 64'd1);
    run_pair(8'h40, 8'h50, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
